// File: rtl/mbist_pkg.sv
// Shared types and constants for the MBIST engine.
// The pattern codes are the selector values understood by the pattern decoder.
package mbist_pkg;

  localparam int PAT_W                = 3;
  localparam int NUM_PATTERNS_DEFAULT = 6;

  localparam logic [PAT_W-1:0] PAT_CHK_AA = 3'd0;
  localparam logic [PAT_W-1:0] PAT_CHK_55 = 3'd1;
  localparam logic [PAT_W-1:0] PAT_ZEROS  = 3'd2;
  localparam logic [PAT_W-1:0] PAT_NIB_0F = 3'd3;
  localparam logic [PAT_W-1:0] PAT_NIB_F0 = 3'd4;
  localparam logic [PAT_W-1:0] PAT_ONES   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mbist_addr_gen.sv
// Address counter for the MBIST array sweep.
// Clear has priority over increment; o_last flags the final word.
module mbist_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = &r_addr;

endmodule

// File: rtl/mbist_controller.sv
// MBIST sequencing FSM: for each pattern code, a write pass then a read/compare pass.
// Records the first failing address and pattern; optionally aborts on the first mismatch.
module mbist_controller
  import mbist_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 8,
  parameter int NUM_PATTERNS = NUM_PATTERNS_DEFAULT,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PAT_W-1:0]  pattern_sel,
  input  logic [DATA_W-1:0] data_t,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [PAT_W-1:0]  fail_pattern
);

  localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [PAT_W-1:0]  r_pat;
  logic              r_we;
  logic              r_re;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [PAT_W-1:0]  r_fail_pat;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_addr;

  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_inc;
  logic              w_start;
  logic              w_mismatch;
  logic              w_abort;

  // data_t is stable from READ into DRAIN, so it is the expected word for the compare stage
  assign w_mismatch = r_cmp_valid && (mem_rdata != data_t);
  assign w_abort    = STOP_ON_FAIL && w_mismatch &&
                      ((r_state == ST_READ) || (r_state == ST_DRAIN));
  assign w_start    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_WRITE;
      ST_WRITE:         if (w_last) w_next = ST_READ;
      ST_READ: begin
        if (w_abort)     w_next = ST_DONE;
        else if (w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_abort || (r_pat == LAST_PAT)) w_next = ST_DONE;
        else                                w_next = ST_WRITE;
      end
      default:          w_next = ST_IDLE;
    endcase
  end

  // Address only advances while staying inside a pass; every transition restarts it at 0
  assign w_inc = ((r_state == ST_WRITE) || (r_state == ST_READ)) && (w_next == r_state);

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (!w_inc),
    .i_inc  (w_inc),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat       <= PAT_CHK_AA;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_pat  <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
    end else begin
      r_we        <= (w_next == ST_WRITE);
      r_re        <= (w_next == ST_READ);
      r_busy      <= (w_next == ST_WRITE) || (w_next == ST_READ) || (w_next == ST_DRAIN);
      r_done      <= (w_next == ST_DONE);
      r_cmp_valid <= r_re && !w_abort;
      r_cmp_addr  <= w_addr;

      if (w_start) begin
        r_pat <= PAT_CHK_AA;
      end else if ((r_state == ST_DRAIN) && (w_next == ST_WRITE)) begin
        r_pat <= r_pat + 1'b1;
      end

      if (w_start) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_pat  <= '0;
      end else if (w_mismatch && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_pat  <= r_pat;
      end
    end
  end

  assign pattern_sel  = r_pat;
  assign mem_addr     = w_addr;
  assign mem_wdata    = data_t;
  assign mem_we       = r_we;
  assign mem_re       = r_re;
  assign busy         = r_busy;
  assign done         = r_done;
  assign fail         = r_fail;
  assign fail_addr    = r_fail_addr;
  assign fail_pattern = r_fail_pat;

endmodule

// File: tb/tb_mbist_controller.sv
// Scoreboard bench for mbist_controller: two instances (abort / full sweep) on 4-word RAM models
// with an optional bit0 stuck-at-0 fault at address 2.
module tb_mbist_controller;

  localparam logic [7:0] PAT_TBL [6] = '{8'hAA, 8'h55, 8'h00, 8'h0F, 8'hF0, 8'hFF};

  typedef struct {
    int cycles;
    int fail;
    int addr;
    int pat;
    int maxpat;
  } res_t;

  logic clk;
  logic rst;
  logic start_c, start_s;
  logic fault;
  logic mon_en;

  logic [2:0] sel_c, sel_s, fpat_c, fpat_s;
  logic [7:0] dt_c, dt_s, wd_c, wd_s, rd_c, rd_s;
  logic [1:0] addr_c, addr_s, faddr_c, faddr_s;
  logic       we_c, we_s, re_c, re_s, busy_c, busy_s, done_c, done_s, fail_c, fail_s;

  logic [7:0] mem_c [4];
  logic [7:0] mem_s [4];

  int n_checks = 0;
  int n_errors = 0;

  res_t q_res_c[$];
  res_t q_res_s[$];
  int   q_wr_c[$];

  function automatic logic [7:0] pat_val(input logic [2:0] code);
    if (code < 3'd6) return PAT_TBL[code];
    return 8'hxx;
  endfunction

  assign dt_c = pat_val(sel_c);
  assign dt_s = pat_val(sel_s);

  mbist_controller #(.ADDR_W(2), .DATA_W(8), .NUM_PATTERNS(6), .STOP_ON_FAIL(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .pattern_sel(sel_c), .data_t(dt_c),
    .mem_addr(addr_c), .mem_wdata(wd_c), .mem_we(we_c), .mem_re(re_c), .mem_rdata(rd_c),
    .busy(busy_c), .done(done_c), .fail(fail_c), .fail_addr(faddr_c), .fail_pattern(fpat_c)
  );

  mbist_controller #(.ADDR_W(2), .DATA_W(8), .NUM_PATTERNS(6), .STOP_ON_FAIL(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .pattern_sel(sel_s), .data_t(dt_s),
    .mem_addr(addr_s), .mem_wdata(wd_s), .mem_we(we_s), .mem_re(re_s), .mem_rdata(rd_s),
    .busy(busy_s), .done(done_s), .fail(fail_s), .fail_addr(faddr_s), .fail_pattern(fpat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: synchronous write, one-cycle read latency, optional stuck-at-0 on bit0 of word 2
  always @(posedge clk) begin
    if (we_c) mem_c[addr_c] <= wd_c;
    if (re_c) rd_c <= (fault && addr_c == 2'd2) ? (mem_c[addr_c] & 8'hFE) : mem_c[addr_c];
    if (we_s) mem_s[addr_s] <= wd_s;
    if (re_s) rd_s <= (fault && addr_s == 2'd2) ? (mem_s[addr_s] & 8'hFE) : mem_s[addr_s];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic exp_res(input bit to_s, input int cyc, input int f, input int a, input int p,
                         input int mp);
    res_t e;
    e.cycles = cyc; e.fail = f; e.addr = a; e.pat = p; e.maxpat = mp;
    if (to_s) q_res_s.push_back(e);
    else      q_res_c.push_back(e);
  endtask

  task automatic push_writes(input int npat);
    for (int p = 0; p < npat; p++)
      for (int a = 0; a < 4; a++)
        q_wr_c.push_back((a << 8) | int'(PAT_TBL[p]));
  endtask

  task automatic pulse_start();
    start_c = 1'b1;
    start_s = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(done_c && done_s) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done_c && done_s)) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: done_c=%0b done_s=%0b after %0d cycles", name, done_c, done_s, n);
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_busy_c"},  int'(busy_c), 0);
    chk({name, "_done_c"},  int'(done_c), 0);
    chk({name, "_fail_c"},  int'(fail_c), 0);
    chk({name, "_we_c"},    int'(we_c), 0);
    chk({name, "_re_c"},    int'(re_c), 0);
    chk({name, "_addr_c"},  int'(addr_c), 0);
    chk({name, "_sel_c"},   int'(sel_c), 0);
    chk({name, "_faddr_c"}, int'(faddr_c), 0);
    chk({name, "_fpat_c"},  int'(fpat_c), 0);
    chk({name, "_busy_s"},  int'(busy_s), 0);
    chk({name, "_done_s"},  int'(done_s), 0);
  endtask

  // Monitor for the full-sweep instance: run results on done rising, write stream on mem_we
  int   cnt_c = 0;
  int   max_c = 0;
  logic pdone_c = 1'b0;
  always @(negedge clk) begin
    res_t r;
    int   w;
    if (mon_en) begin
      if (rst) begin
        cnt_c = 0;
        max_c = 0;
      end else begin
        if (busy_c) begin
          cnt_c++;
          if (int'(sel_c) > max_c) max_c = int'(sel_c);
        end
        if (done_c && !pdone_c) begin
          if (q_res_c.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL c_done_unexpected: done rose with no run expected");
          end else begin
            r = q_res_c.pop_front();
            chk("c_busy_cycles", cnt_c, r.cycles);
            chk("c_fail", int'(fail_c), r.fail);
            chk("c_fail_addr", int'(faddr_c), r.addr);
            chk("c_fail_pattern", int'(fpat_c), r.pat);
            chk("c_max_pattern_sel", max_c, r.maxpat);
          end
          cnt_c = 0;
          max_c = 0;
        end
        if (we_c) begin
          if (q_wr_c.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL c_write_unexpected: addr=%0d wdata=0x%0h", addr_c, wd_c);
          end else begin
            w = q_wr_c.pop_front();
            chk("c_wr_addr", int'(addr_c), (w >> 8) & 3);
            chk("c_wr_data", int'(wd_c), w & 8'hFF);
          end
        end
      end
      pdone_c = done_c;
    end
  end

  // Monitor for the abort-on-fail instance
  int   cnt_s = 0;
  int   max_s = 0;
  logic pdone_s = 1'b0;
  always @(negedge clk) begin
    res_t r;
    if (mon_en) begin
      if (rst) begin
        cnt_s = 0;
        max_s = 0;
      end else begin
        if (busy_s) begin
          cnt_s++;
          if (int'(sel_s) > max_s) max_s = int'(sel_s);
        end
        if (done_s && !pdone_s) begin
          if (q_res_s.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL s_done_unexpected: done rose with no run expected");
          end else begin
            r = q_res_s.pop_front();
            chk("s_busy_cycles", cnt_s, r.cycles);
            chk("s_fail", int'(fail_s), r.fail);
            chk("s_fail_addr", int'(faddr_s), r.addr);
            chk("s_fail_pattern", int'(fpat_s), r.pat);
            chk("s_max_pattern_sel", max_s, r.maxpat);
          end
          cnt_s = 0;
          max_s = 0;
        end
      end
      pdone_s = done_s;
    end
  end

  initial begin
    int act;
    rst     = 1'b0;
    start_c = 1'b0;
    start_s = 1'b0;
    fault   = 1'b0;
    mon_en  = 1'b0;

    // 1: asynchronous reset mid-cycle, then idle with start low
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("t1_reset");
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    act    = 0;
    repeat (6) begin
      @(negedge clk);
      if (we_c || re_c || we_s || re_s || busy_c || busy_s) act++;
    end
    chk("t1_idle_activity", act, 0);

    // 2: fault-free sweep on both instances
    push_writes(6);
    exp_res(1'b0, 54, 0, 0, 0, 5);
    exp_res(1'b1, 54, 0, 0, 0, 5);
    pulse_start();
    wait_done("t2", 200);

    // 3/4: bit0 stuck-at-0 at address 2; abort instance stops in pattern 1
    fault = 1'b1;
    push_writes(6);
    exp_res(1'b0, 54, 1, 2, 1, 5);
    exp_res(1'b1, 17, 1, 2, 1, 1);
    pulse_start();
    wait_done("t3", 200);

    // 5: restart from a failing DONE clears results; start while busy is ignored
    fault = 1'b0;
    push_writes(6);
    exp_res(1'b0, 54, 0, 0, 0, 5);
    exp_res(1'b1, 54, 0, 0, 0, 5);
    pulse_start();
    chk("t5_done_cleared_c", int'(done_c), 0);
    chk("t5_fail_cleared_c", int'(fail_c), 0);
    chk("t5_faddr_cleared_c", int'(faddr_c), 0);
    chk("t5_fpat_cleared_c", int'(fpat_c), 0);
    chk("t5_fail_cleared_s", int'(fail_s), 0);
    chk("t5_fpat_cleared_s", int'(fpat_s), 0);
    chk("t5_sel_restart_c", int'(sel_c), 0);
    chk("t5_busy_c", int'(busy_c), 1);
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done("t5", 200);

    // 6: reset during the read pass of pattern 3, then a clean run
    push_writes(4);
    pulse_start();
    repeat (32) @(negedge clk);
    chk("t6_sel_before_rst", int'(sel_c), 3);
    chk("t6_re_before_rst", int'(re_c), 1);
    #2 rst = 1'b1;
    #1 check_reset("t6_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_writes(6);
    exp_res(1'b0, 54, 0, 0, 0, 5);
    exp_res(1'b1, 54, 0, 0, 0, 5);
    pulse_start();
    wait_done("t6", 200);
    repeat (2) @(negedge clk);

    chk("end_write_queue_c", q_wr_c.size(), 0);
    chk("end_result_queue_c", q_res_c.size(), 0);
    chk("end_result_queue_s", q_res_s.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mbist_controller.md
Name: mbist_controller

Overview:
Sequencing FSM for the MBIST engine. It steps the pattern decoder's 3-bit selector through codes 0..5. For each pattern it runs a full-array write pass followed by a full-array read/compare pass against the RAM under test. It reports pass/fail, and on failure the first failing address and pattern code. It sits between the test-mode start request and the pattern decoder plus RAM port mux.

Parameters:
ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W words
DATA_W, 8, RAM word width; must equal decoder output width
NUM_PATTERNS, 6, number of pattern codes swept (0..NUM_PATTERNS-1)
STOP_ON_FAIL, 1, 1 = abort to DONE on first mismatch; 0 = finish the full sweep

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  run request, level-sampled in IDLE/DONE
pattern_sel  out  3  selector code to pattern decoder q
data_t  in  DATA_W  pattern from decoder (combinational function of pattern_sel)
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data; direct pass-through of data_t
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable; RAM returns mem_rdata one cycle later
mem_rdata  in  DATA_W  RAM read data
busy  out  1  test in progress
done  out  1  test finished; level, held until next start
fail  out  1  sticky mismatch flag for the current run
fail_addr  out  ADDR_W  address of first mismatch
fail_pattern  out  3  pattern code of first mismatch

Behaviour:
- Reset is asynchronous and active-high: state=IDLE; pattern_sel, mem_addr, fail_addr, fail_pattern = 0; mem_we, mem_re, busy, done, fail = 0; compare pipeline invalid.
- All outputs come from registers. The only exception is mem_wdata = data_t.
- States are IDLE, WRITE, READ, DRAIN and DONE.
- IDLE/DONE with start=1 at an edge:
  - go to WRITE with pattern_sel=0, mem_addr=0.
  - clear fail, fail_addr, fail_pattern and done.
- start is ignored in WRITE, READ and DRAIN.
- WRITE:
  - mem_we=1, mem_re=0.
  - mem_addr increments every cycle.
  - at mem_addr=DEPTH-1, go to READ with mem_addr=0.
- READ:
  - mem_re=1, mem_we=0.
  - mem_addr increments every cycle.
  - at mem_addr=DEPTH-1, go to DRAIN.
- DRAIN:
  - mem_we=0, mem_re=0.
  - Performs the last compare.
  - Then, if pattern_sel=NUM_PATTERNS-1, go to DONE.
  - Otherwise pattern_sel+1 and go to WRITE with mem_addr=0.
- Compare pipeline:
  - cmp_valid and cmp_addr register mem_re and mem_addr.
  - A mismatch is cmp_valid && mem_rdata != data_t. pattern_sel is constant across READ→DRAIN, so data_t is the expected value.
- On a mismatch:
  - If fail=0: set fail=1 and capture fail_addr=cmp_addr, fail_pattern=pattern_sel.
  - Later mismatches do not overwrite the captured values.
- STOP_ON_FAIL=1: a mismatch in READ or DRAIN moves to DONE at that edge. mem_re drops, the pipeline is invalidated, and the remaining patterns are skipped.
- busy=1 exactly in WRITE/READ/DRAIN. done=1 exactly in DONE.
- Latency, fault-free: busy holds for NUM_PATTERNS*(2*DEPTH+1) cycles after the start edge, then done rises. With defaults this is 774 cycles.
- NUM_PATTERNS must be ≤ 8. Codes 6/7 give X patterns from the decoder and must never be driven.
- Reset mid-run: immediate return to IDLE and reset values. Partial results are discarded.

Decomposition:
- Package mbist_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE).
  - PAT_W=3 and NUM_PATTERNS_DEFAULT=6.
  - named pattern-code constants (PAT_CHK_AA=0 … PAT_ONES=5).
- One sub-module, mbist_addr_gen:
  - ADDR_W counter with clear/increment inputs and a last flag (addr==DEPTH-1).
  - Async reset to 0.

Test Plan:
1. Reset: assert rst mid-cycle → all outputs 0 immediately; state IDLE; start held 0 → no mem_we/mem_re activity.
2. ADDR_W=2, fault-free RAM model with decoder attached, 1-cycle start:
   - busy for 54 cycles, then done=1, fail=0.
   - First 4 cycles: we=1, addr 0..3, wdata 0xAA.
   - Last pattern writes 0xFF.
3. ADDR_W=2, STOP_ON_FAIL=1, bit0 of addr 2 stuck-at-0:
   - pattern 0 (0xAA) passes.
   - pattern 1 (0x55) fails → fail=1, fail_addr=2, fail_pattern=1, done=1 well before 54 cycles.
   - pattern_sel never reaches 2.
4. Same fault, STOP_ON_FAIL=0:
   - full 54-cycle run, done=1.
   - fail_addr=2, fail_pattern=1 retained despite later mismatch at pattern 3 (0x0F).
5. start pulsed again while busy → ignored, cycle count unchanged. start in DONE after a failing run → fail/fail_addr/fail_pattern cleared, done drops, new sweep begins at pattern 0.
6. rst asserted during READ of pattern 3 → immediate IDLE/reset values. A following start completes a clean 54-cycle fault-free run.
